// File: rtl/ctrl_pkg.sv
// Shared definitions for the alu_ctrl_seq controller: opcodes, FSM states,
// instruction field positions and a small decode helper.
package ctrl_pkg;

   localparam int DW    = 8;   // datapath width
   localparam int PCW   = 8;   // program counter width
   localparam int IW    = 9;   // instruction width
   localparam int RW    = 3;   // register index width
   localparam int NREGS = 8;

   // Instruction fields: op = instr[8:5], imm = instr[4:0], r = instr[2:0]
   localparam int OP_MSB  = 8;
   localparam int OP_LSB  = 5;
   localparam int IMM_MSB = 4;
   localparam int IMM_LSB = 0;
   localparam int R_MSB   = 2;
   localparam int R_LSB   = 0;

   // R7 is the implicit rt operand, set target and memory address register
   localparam logic [RW-1:0] R_ACC = 3'd7;

   localparam logic [3:0] OP_AND  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SLL  = 4'h2;
   localparam logic [3:0] OP_SRL  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_SLT  = 4'h5;
   localparam logic [3:0] OP_ABS  = 4'h6;
   localparam logic [3:0] OP_SEQ  = 4'h7;
   localparam logic [3:0] OP_SET  = 4'h8;
   localparam logic [3:0] OP_ADDC = 4'h9;
   localparam logic [3:0] OP_LW   = 4'hA;
   localparam logic [3:0] OP_SW   = 4'hB;
   localparam logic [3:0] OP_BCB  = 4'hC;
   localparam logic [3:0] OP_NOP0 = 4'hD;
   localparam logic [3:0] OP_NOP1 = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_e;

   // Branch offset: 5-bit two's-complement immediate widened to the PC width
   function automatic logic [PCW-1:0] sext_imm(input logic [4:0] imm);
      return {{(PCW-5){imm[4]}}, imm};
   endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Bus bundle between the controller and its environment (instruction
// memory, data memory, ALU).
// Protocol: no handshake. Both memories answer with a fixed one-cycle read
// latency (data valid the cycle after the address is presented), the store
// strobe dmem_we is a single-cycle pulse qualifying dmem_addr/dmem_wdata, and
// the ALU is purely combinational from the registered operand outputs.
interface alu_ctrl_seq_if;
   logic [7:0] imem_addr;
   logic [8:0] imem_data;
   logic [7:0] dmem_addr;
   logic [7:0] dmem_wdata;
   logic       dmem_we;
   logic [7:0] dmem_rdata;
   logic [3:0] alu_opcode;
   logic [7:0] alu_rs;
   logic [7:0] alu_rt;
   logic [4:0] alu_imm;
   logic [7:0] alu_result;
   logic       alu_cb;

   modport ctrl (
      output imem_addr, dmem_addr, dmem_wdata, dmem_we,
             alu_opcode, alu_rs, alu_rt, alu_imm,
      input  imem_data, dmem_rdata, alu_result, alu_cb
   );

   modport env (
      input  imem_addr, dmem_addr, dmem_wdata, dmem_we,
             alu_opcode, alu_rs, alu_rt, alu_imm,
      output imem_data, dmem_rdata, alu_result, alu_cb
   );
endinterface

// File: rtl/ctrl_regfile.sv
// 8x8 register file: two combinational read ports, one synchronous write
// port, synchronous clear on reset.
module ctrl_regfile
   import ctrl_pkg::*;
(
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic [RW-1:0] ra_idx_i,
   output logic [DW-1:0] ra_data_o,
   input  logic [RW-1:0] rb_idx_i,
   output logic [DW-1:0] rb_data_o,
   input  logic          we_i,
   input  logic [RW-1:0] wa_idx_i,
   input  logic [DW-1:0] wd_i
);

   logic [DW-1:0] regs_q [NREGS];
   logic [DW-1:0] regs_d [NREGS];

   assign ra_data_o = regs_q[ra_idx_i];
   assign rb_data_o = regs_q[rb_idx_i];

   // Next register contents: single write port
   always_comb begin
      regs_d = regs_q;
      if (we_i) begin
         regs_d[wa_idx_i] = wd_i;
      end
   end

   // Storage; reset wins over a write in the same cycle
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Multi-cycle fetch/decode/exec/mem/writeback controller for the 8-bit
// datapath. Owns the PC, the register file and the condition bit; drives an
// external combinational ALU and the instruction/data memories.
module alu_ctrl_seq
   import ctrl_pkg::*;
(
   input  logic           clk_i,
   input  logic           reset_i,
   input  logic           start_i,
   output logic [PCW-1:0] imem_addr_o,
   input  logic [IW-1:0]  imem_data_i,
   output logic [DW-1:0]  dmem_addr_o,
   output logic [DW-1:0]  dmem_wdata_o,
   output logic           dmem_we_o,
   input  logic [DW-1:0]  dmem_rdata_i,
   output logic [3:0]     alu_opcode_o,
   output logic [DW-1:0]  alu_rs_o,
   output logic [DW-1:0]  alu_rt_o,
   output logic [4:0]     alu_imm_o,
   input  logic [DW-1:0]  alu_result_i,
   input  logic           alu_cb_i,
   output logic           cb_o,
   output logic           done_o,
   output logic [15:0]    instr_count_o,
   output state_e         dbg_state_o
);

   state_e         state_q, state_d;
   logic [PCW-1:0] pc_q, pc_d;
   logic           cb_q, cb_d;
   logic [IW-1:0]  ir_q, ir_d;
   logic [DW-1:0]  alu_rs_q, alu_rs_d;
   logic [DW-1:0]  alu_rt_q, alu_rt_d;
   logic [DW-1:0]  dmem_addr_q, dmem_addr_d;
   logic [DW-1:0]  dmem_wdata_q, dmem_wdata_d;
   logic           dmem_we_q, dmem_we_d;
   logic           done_q, done_d;
   logic [15:0]    count_q, count_d;
   logic [DW-1:0]  res_q, res_d;

   logic [3:0]     dec_op, ex_op;
   logic [4:0]     dec_imm;
   logic [RW-1:0]  dec_r, ex_r;
   logic [DW-1:0]  rf_rs_data, rf_rt_data;
   logic           rf_we;
   logic [RW-1:0]  rf_wa;
   logic [15:0]    count_inc;
   logic [PCW-1:0] pc_inc;

   // DECODE works on the instruction arriving from memory; later states use IR
   assign dec_op  = imem_data_i[OP_MSB:OP_LSB];
   assign dec_imm = imem_data_i[IMM_MSB:IMM_LSB];
   assign dec_r   = imem_data_i[R_MSB:R_LSB];
   assign ex_op   = ir_q[OP_MSB:OP_LSB];
   assign ex_r    = ir_q[R_MSB:R_LSB];

   assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
   assign pc_inc    = pc_q + 8'd1;

   // Writeback happens only in WB; set always targets R7
   assign rf_we = (state_q == ST_WB);
   assign rf_wa = (ex_op == OP_SET) ? R_ACC : ex_r;

   ctrl_regfile u_regfile (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .ra_idx_i  (dec_r),
      .ra_data_o (rf_rs_data),
      .rb_idx_i  (R_ACC),
      .rb_data_o (rf_rt_data),
      .we_i      (rf_we),
      .wa_idx_i  (rf_wa),
      .wd_i      (res_q)
   );

   // Next-state and datapath register computation for the sequencer
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      cb_d         = cb_q;
      ir_d         = ir_q;
      alu_rs_d     = alu_rs_q;
      alu_rt_d     = alu_rt_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      dmem_we_d    = 1'b0;
      done_d       = done_q;
      count_d      = count_q;
      res_d        = res_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_FETCH;
               pc_d    = '0;
            end
         end

         ST_FETCH: begin
            state_d = ST_DECODE;
         end

         ST_DECODE: begin
            // Operands are registered here so the ALU inputs stay stable in EXEC
            ir_d     = imem_data_i;
            alu_rs_d = rf_rs_data;
            alu_rt_d = rf_rt_data;
            if (dec_op == OP_LW || dec_op == OP_SW) begin
               dmem_addr_d  = rf_rt_data;
               dmem_wdata_d = rf_rs_data;
            end
            case (dec_op)
               OP_HALT: begin
                  state_d = ST_HALT;
                  done_d  = 1'b1;
                  count_d = count_inc;
               end
               OP_BCB: begin
                  pc_d    = cb_q ? (pc_q + sext_imm(dec_imm)) : pc_inc;
                  state_d = ST_FETCH;
                  count_d = count_inc;
               end
               OP_NOP0, OP_NOP1: begin
                  pc_d    = pc_inc;
                  state_d = ST_FETCH;
                  count_d = count_inc;
               end
               default: begin
                  state_d = ST_EXEC;
               end
            endcase
         end

         ST_EXEC: begin
            case (ex_op)
               OP_LW: begin
                  state_d = ST_MEM;
               end
               OP_SW: begin
                  state_d   = ST_MEM;
                  dmem_we_d = 1'b1;
               end
               OP_SLT, OP_SEQ: begin
                  cb_d    = alu_cb_i;
                  pc_d    = pc_inc;
                  state_d = ST_FETCH;
                  count_d = count_inc;
               end
               default: begin
                  res_d   = alu_result_i;
                  state_d = ST_WB;
               end
            endcase
         end

         ST_MEM: begin
            if (ex_op == OP_SW) begin
               pc_d    = pc_inc;
               state_d = ST_FETCH;
               count_d = count_inc;
            end else begin
               // Address has been stable since EXEC, so read data is valid now
               res_d   = dmem_rdata_i;
               state_d = ST_WB;
            end
         end

         ST_WB: begin
            pc_d    = pc_inc;
            state_d = ST_FETCH;
            count_d = count_inc;
         end

         ST_HALT: begin
            if (start_i) begin
               state_d = ST_FETCH;
               pc_d    = '0;
               done_d  = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer registers; synchronous reset clears everything
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         pc_q         <= '0;
         cb_q         <= 1'b0;
         ir_q         <= '0;
         alu_rs_q     <= '0;
         alu_rt_q     <= '0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         dmem_we_q    <= 1'b0;
         done_q       <= 1'b0;
         count_q      <= '0;
         res_q        <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         cb_q         <= cb_d;
         ir_q         <= ir_d;
         alu_rs_q     <= alu_rs_d;
         alu_rt_q     <= alu_rt_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         dmem_we_q    <= dmem_we_d;
         done_q       <= done_d;
         count_q      <= count_d;
         res_q        <= res_d;
      end
   end

   assign imem_addr_o   = pc_q;
   assign dmem_addr_o   = dmem_addr_q;
   assign dmem_wdata_o  = dmem_wdata_q;
   // A reset arriving during MEM of a store must not let that store land
   assign dmem_we_o     = dmem_we_q & ~reset_i;
   assign alu_opcode_o  = ir_q[OP_MSB:OP_LSB];
   assign alu_imm_o     = ir_q[IMM_MSB:IMM_LSB];
   assign alu_rs_o      = alu_rs_q;
   assign alu_rt_o      = alu_rt_q;
   assign cb_o          = cb_q;
   assign done_o        = done_q;
   assign instr_count_o = count_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: instruction/data memory and ALU models,
// a store scoreboard, and cycle-level checks of PC, CB, done and count.
module tb_alu_ctrl_seq;
   import ctrl_pkg::*;

   logic        clk;
   logic        reset_i;
   logic        start_i;
   logic        cb_o;
   logic        done_o;
   logic [15:0] instr_count_o;
   state_e      dbg_state;

   alu_ctrl_seq_if bus ();

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] exp_q[$];   // expected stores {addr, wdata}
   logic [8:0]  imem [256];
   logic [7:0]  dmem [256];

   alu_ctrl_seq dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .start_i       (start_i),
      .imem_addr_o   (bus.imem_addr),
      .imem_data_i   (bus.imem_data),
      .dmem_addr_o   (bus.dmem_addr),
      .dmem_wdata_o  (bus.dmem_wdata),
      .dmem_we_o     (bus.dmem_we),
      .dmem_rdata_i  (bus.dmem_rdata),
      .alu_opcode_o  (bus.alu_opcode),
      .alu_rs_o      (bus.alu_rs),
      .alu_rt_o      (bus.alu_rt),
      .alu_imm_o     (bus.alu_imm),
      .alu_result_i  (bus.alu_result),
      .alu_cb_i      (bus.alu_cb),
      .cb_o          (cb_o),
      .done_o        (done_o),
      .instr_count_o (instr_count_o),
      .dbg_state_o   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- environment models ----------------
   // Memories with one-cycle read latency
   always @(posedge clk) begin
      bus.imem_data  <= imem[bus.imem_addr];
      bus.dmem_rdata <= dmem[bus.dmem_addr];
      if (bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
   end

   // Combinational reference ALU
   always_comb begin
      bus.alu_result = 8'h00;
      bus.alu_cb     = 1'b0;
      case (bus.alu_opcode)
         OP_AND:  bus.alu_result = bus.alu_rs & bus.alu_rt;
         OP_ADD:  bus.alu_result = bus.alu_rs + bus.alu_rt;
         OP_SLL:  bus.alu_result = bus.alu_rs << bus.alu_rt[2:0];
         OP_SRL:  bus.alu_result = bus.alu_rs >> bus.alu_rt[2:0];
         OP_SUB:  bus.alu_result = bus.alu_rs - bus.alu_rt;
         OP_SLT:  bus.alu_cb     = ($signed(bus.alu_rs) < $signed(bus.alu_rt));
         OP_ABS:  bus.alu_result = bus.alu_rs[7] ? (8'h00 - bus.alu_rs) : bus.alu_rs;
         OP_SEQ:  bus.alu_cb     = (bus.alu_rs == bus.alu_rt);
         OP_SET:  bus.alu_result = {3'b000, bus.alu_imm};
         OP_ADDC: bus.alu_result = bus.alu_rs + bus.alu_rt;
         default: bus.alu_result = 8'h00;
      endcase
   end

   // ---------------- helpers / driver tasks ----------------
   function automatic logic [8:0] enc(input logic [3:0] op, input logic [4:0] imm);
      return {op, imm};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) imem[i] = enc(OP_HALT, 5'd0);
   endtask

   task automatic start_prog(input string tag);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check({tag, "_fetch_state"}, 32'(dbg_state), 32'(ST_FETCH));
      check({tag, "_fetch_pc0"}, 32'(bus.imem_addr), 32'h00);
      check({tag, "_done_low"}, 32'(done_o), 32'd0);
   endtask

   task automatic run_until_done(input string tag, input int max_cycles);
      int n;
      n = 0;
      while (done_o !== 1'b1 && n < max_cycles) begin
         tick();
         n++;
      end
      check({tag, "_done"}, 32'(done_o), 32'd1);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_state"},  32'(dbg_state),          32'(ST_IDLE));
      check({tag, "_imem"},   32'(bus.imem_addr),      32'h0);
      check({tag, "_daddr"},  32'(bus.dmem_addr),      32'h0);
      check({tag, "_wdata"},  32'(bus.dmem_wdata),     32'h0);
      check({tag, "_we"},     32'(bus.dmem_we),        32'h0);
      check({tag, "_aluop"},  32'(bus.alu_opcode),     32'h0);
      check({tag, "_rs"},     32'(bus.alu_rs),         32'h0);
      check({tag, "_rt"},     32'(bus.alu_rt),         32'h0);
      check({tag, "_imm"},    32'(bus.alu_imm),        32'h0);
      check({tag, "_cb"},     32'(cb_o),               32'h0);
      check({tag, "_done"},   32'(done_o),             32'h0);
      check({tag, "_count"},  32'(instr_count_o),      32'h0);
   endtask

   // ---------------- scoreboard: store monitor ----------------
   always @(negedge clk) begin
      if (reset_i === 1'b0 && bus.dmem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("store_unexpected", 32'(exp_q.size()), 32'd1);
         end else begin
            check("store", {16'h0, bus.dmem_addr, bus.dmem_wdata}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      reset_i = 1'b1;
      start_i = 1'b0;
      for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
      clear_imem();
      step(3);
      check_reset("rst");
      reset_i = 1'b0;
      tick();
      check_reset("idle");

      // T1: set 5 ; add r1 ; sw r1 ; halt
      imem[0] = enc(OP_SET, 5'd5);
      imem[1] = enc(OP_ADD, 5'd1);
      imem[2] = enc(OP_SW,  5'd1);
      imem[3] = enc(OP_HALT, 5'd0);
      exp_q.push_back({8'h05, 8'h05});
      start_prog("t1");
      step(4);
      check("t1_set_count", 32'(instr_count_o), 32'd1);
      check("t1_set_pc", 32'(bus.imem_addr), 32'h01);
      step(2);
      check("t1_add_exec_op", 32'(bus.alu_opcode), 32'(OP_ADD));
      check("t1_add_exec_rs", 32'(bus.alu_rs), 32'h00);
      check("t1_add_exec_rt", 32'(bus.alu_rt), 32'h05);
      step(2);
      check("t1_add_count", 32'(instr_count_o), 32'd2);
      check("t1_add_pc", 32'(bus.imem_addr), 32'h02);
      run_until_done("t1", 40);
      check("t1_halt_pc", 32'(bus.imem_addr), 32'h03);
      step(3);
      check("t1_halt_frozen", 32'(bus.imem_addr), 32'h03);
      check("t1_halt_done", 32'(done_o), 32'd1);
      check("t1_count", 32'(instr_count_o), 32'd4);

      // T2: slt sets CB, bcb +3 from PC 4 -> 7; stray start ignored
      clear_imem();
      imem[0] = enc(OP_SET, 5'd3);
      imem[1] = enc(OP_ADD, 5'd2);
      imem[2] = enc(OP_SET, 5'd5);
      imem[3] = enc(OP_SLT, 5'd2);
      imem[4] = enc(OP_BCB, 5'd3);
      imem[5] = enc(OP_SW,  5'd2);
      imem[7] = enc(OP_SW,  5'd2);
      exp_q.push_back({8'h05, 8'h03});
      start_prog("t2");
      step(4);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      step(3);
      check("t2_start_ignored_pc", 32'(bus.imem_addr), 32'h02);
      step(4);
      step(3);
      check("t2_slt_cb", 32'(cb_o), 32'd1);
      check("t2_slt_pc", 32'(bus.imem_addr), 32'h04);
      step(2);
      check("t2_bcb_taken_pc", 32'(bus.imem_addr), 32'h07);
      run_until_done("t2", 40);
      check("t2_count", 32'(instr_count_o), 32'd11);

      // T3: seq equal -> CB=1, seq unequal -> CB=0, bcb falls through
      clear_imem();
      imem[0] = enc(OP_SET, 5'd9);
      imem[1] = enc(OP_ADD, 5'd3);
      imem[2] = enc(OP_SEQ, 5'd3);
      imem[3] = enc(OP_SET, 5'd8);
      imem[4] = enc(OP_AND, 5'd3);
      imem[5] = enc(OP_SET, 5'd9);
      imem[6] = enc(OP_SEQ, 5'd3);
      imem[7] = enc(OP_BCB, 5'd5);
      imem[8] = enc(OP_SW,  5'd3);
      exp_q.push_back({8'h09, 8'h08});
      start_prog("t3");
      step(11);
      check("t3_seq_eq_cb", 32'(cb_o), 32'd1);
      check("t3_seq_eq_pc", 32'(bus.imem_addr), 32'h03);
      step(15);
      check("t3_seq_ne_cb", 32'(cb_o), 32'd0);
      check("t3_seq_ne_pc", 32'(bus.imem_addr), 32'h07);
      step(2);
      check("t3_bcb_fall_pc", 32'(bus.imem_addr), 32'h08);
      run_until_done("t3", 40);
      check("t3_count", 32'(instr_count_o), 32'd21);

      // T4: lw / sw round trip through data memory
      clear_imem();
      dmem[8'h11] = 8'hA5;
      imem[0] = enc(OP_SET, 5'h11);
      imem[1] = enc(OP_LW,  5'd4);
      imem[2] = enc(OP_SET, 5'h10);
      imem[3] = enc(OP_SW,  5'd4);
      imem[4] = enc(OP_LW,  5'd5);
      imem[5] = enc(OP_SET, 5'h12);
      imem[6] = enc(OP_SW,  5'd5);
      exp_q.push_back({8'h10, 8'hA5});
      exp_q.push_back({8'h12, 8'hA5});
      start_prog("t4");
      step(4);
      step(5);
      check("t4_lw_pc", 32'(bus.imem_addr), 32'h02);
      check("t4_lw_count", 32'(instr_count_o), 32'd23);
      step(4);
      step(3);
      check("t4_sw_we", 32'(bus.dmem_we), 32'd1);
      check("t4_sw_addr", 32'(bus.dmem_addr), 32'h10);
      check("t4_sw_wdata", 32'(bus.dmem_wdata), 32'hA5);
      step(1);
      check("t4_sw_we_pulse", 32'(bus.dmem_we), 32'd0);
      check("t4_sw_pc", 32'(bus.imem_addr), 32'h04);
      step(5);
      check("t4_lw5_pc", 32'(bus.imem_addr), 32'h05);
      run_until_done("t4", 40);
      check("t4_count", 32'(instr_count_o), 32'd29);

      // T5: backward branch 2 + (-2) -> 0, branch to FF, no-op wraps to 00
      clear_imem();
      imem[0]     = enc(OP_SET, 5'd1);
      imem[1]     = enc(OP_SEQ, 5'd7);
      imem[2]     = enc(OP_BCB, 5'h1E);
      imem[8'hFF] = enc(OP_NOP0, 5'd0);
      start_prog("t5");
      step(9);
      check("t5_bcb_back_pc", 32'(bus.imem_addr), 32'h00);
      check("t5_cb", 32'(cb_o), 32'd1);
      imem[2] = enc(OP_BCB, 5'h1D);
      step(9);
      check("t5_bcb_ff_pc", 32'(bus.imem_addr), 32'hFF);
      imem[0] = enc(OP_HALT, 5'd0);
      step(2);
      check("t5_wrap_pc", 32'(bus.imem_addr), 32'h00);
      step(2);
      check("t5_halt_done", 32'(done_o), 32'd1);
      check("t5_count", 32'(instr_count_o), 32'd37);

      // T6: reset during WB of add r1 aborts the write
      clear_imem();
      imem[0] = enc(OP_SET, 5'd3);
      imem[1] = enc(OP_ADD, 5'd1);
      start_prog("t6");
      step(7);
      check("t6_in_wb", 32'(dbg_state), 32'(ST_WB));
      reset_i = 1'b1;
      tick();
      check_reset("t6_rst");
      reset_i = 1'b0;
      clear_imem();
      imem[0] = enc(OP_SET, 5'd2);
      imem[1] = enc(OP_SW,  5'd1);
      exp_q.push_back({8'h02, 8'h00});
      tick();
      start_prog("t6b");
      run_until_done("t6b", 40);
      check("t6_count", 32'(instr_count_o), 32'd3);

      step(2);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
